// File: rtl/register_file.sv
// register_file: DEPTH x WIDTH architectural register file with one synchronous write port and
// two combinational read ports. Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module register_file #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 32,
    parameter int ADDR_W  = 5,
    parameter int ZERO_R0 = 1
) (
    input  logic              clock,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_a,
    output logic [WIDTH-1:0]  rdata_b
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0] wen_s;
    logic             wok_s;
    logic [WIDTH-1:0] mux_a_s;
    logic [WIDTH-1:0] mux_b_s;
    logic [WIDTH-1:0] rd_a_s;
    logic [WIDTH-1:0] rd_b_s;

    // An address names real storage only if it is in range and not the hardwired zero entry;
    // the same rule governs which writes land and which reads return stored data.
    function automatic logic addr_valid(input logic [ADDR_W-1:0] addr);
        return (32'(addr) < 32'(DEPTH)) && !((ZERO_R0 != 32'sd0) && (addr == '0));
    endfunction

    // Per-entry write enable decode
    always_comb begin
        wok_s = we && addr_valid(waddr);
        wen_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wen_s[i] = wok_s && (waddr == ADDR_W'(i));
        end
    end

    // Storage array; reset dominates any write in flight
    always_ff @(posedge clock or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wen_s[i]) begin
                    mem_r[i] <= wdata;
                end
            end
        end
    end

    // AND-OR read multiplexers; out-of-range addresses match no entry and fall to zero
    always_comb begin
        mux_a_s = '0;
        mux_b_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mux_a_s = mux_a_s | ({WIDTH{raddr_a == ADDR_W'(i)}} & mem_r[i]);
            mux_b_s = mux_b_s | ({WIDTH{raddr_b == ADDR_W'(i)}} & mem_r[i]);
        end
        rd_a_s = addr_valid(raddr_a) ? mux_a_s : '0;
        rd_b_s = addr_valid(raddr_b) ? mux_b_s : '0;
    end

    // Read port outputs, optionally forwarding the write in flight
    always_comb begin
`ifdef REGFILE_BYPASS_EN
        rdata_a = (wok_s && clr && (raddr_a == waddr)) ? wdata : rd_a_s;
        rdata_b = (wok_s && clr && (raddr_b == waddr)) ? wdata : rd_b_s;
`else
        rdata_a = rd_a_s;
        rdata_b = rd_b_s;
`endif
    end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: three instances (32x32 zero-r0, 24-deep plain r0,
// 4x8) driven from one sequence; expected read data comes from a reference model via a queue.
module tb_register_file;

    logic        clock = 1'b0;
    logic        clr;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr_a, raddr_b;
    logic [31:0] rdata_a, rdata_b, rd_a_24, rd_b_24;
    logic        we8;
    logic [1:0]  waddr8, ra8, rb8;
    logic [7:0]  wdata8, rd_a8, rd_b8;

    int errors = 0;
    int checks = 0;
    logic [31:0] mdl32 [32];
    logic [31:0] mdl24 [32];
    logic [7:0]  mdl8  [4];
    logic [31:0] exp_q [$];
    logic [31:0] exp_v;
    logic [31:0] pre_v;
    int          waddrs [6];

    always #5 clock = ~clock;

    register_file dut (
        .clock(clock), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a), .rdata_b(rdata_b)
    );

    register_file #(.WIDTH(32), .DEPTH(24), .ADDR_W(5), .ZERO_R0(0)) dut24 (
        .clock(clock), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rd_a_24), .rdata_b(rd_b_24)
    );

    register_file #(.WIDTH(8), .DEPTH(4), .ADDR_W(2), .ZERO_R0(1)) dut8 (
        .clock(clock), .clr(clr), .we(we8), .waddr(waddr8), .wdata(wdata8),
        .raddr_a(ra8), .raddr_b(rb8), .rdata_a(rd_a8), .rdata_b(rd_b8)
    );

    function automatic logic [31:0] exp32(input int a);
        return (a == 0) ? 32'd0 : mdl32[a];
    endfunction

    function automatic logic [31:0] exp24(input int a);
        return (a >= 24) ? 32'd0 : mdl24[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            mdl32[i] = 32'd0;
            mdl24[i] = 32'd0;
        end
        for (int i = 0; i < 4; i++) mdl8[i] = 8'd0;
    endtask

    task automatic model_write(input int a, input logic [31:0] d);
        if (a != 0) mdl32[a] = d;
        if (a < 24) mdl24[a] = d;
    endtask

    task automatic do_write(input int a, input logic [31:0] d);
        @(negedge clock);
        we = 1'b1; waddr = a[4:0]; wdata = d;
        @(posedge clock);
        model_write(a, d);
        #1;
        we = 1'b0;
    endtask

    task automatic test_reset();
        #2 clr = 1'b0;
        model_clear();
        raddr_a = 5'd5; raddr_b = 5'd20;
        exp_q.push_back(exp32(5)); exp_q.push_back(exp24(20));
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (rdata_a !== exp_v) begin errors++; $display("FAIL reset_init_a got=%h exp=%h", rdata_a, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (rd_b_24 !== exp_v) begin errors++; $display("FAIL reset_init_b24 got=%h exp=%h", rd_b_24, exp_v); end
        @(negedge clock) clr = 1'b1;
        for (int k = 0; k < 6; k++) begin
            waddrs[k] = int'($urandom_range(1, 23));
            do_write(waddrs[k], $urandom | 32'h0000_0001);
        end
        @(posedge clock);
        #3 clr = 1'b0;
        model_clear();
        for (int k = 0; k < 6; k++) begin
            raddr_a = waddrs[k][4:0]; raddr_b = waddrs[k][4:0];
            exp_q.push_back(exp32(waddrs[k])); exp_q.push_back(exp24(waddrs[k]));
            #1;
            exp_v = exp_q.pop_front(); checks++;
            if (rdata_a !== exp_v) begin errors++; $display("FAIL reset_mid_a addr=%0d got=%h exp=%h", waddrs[k], rdata_a, exp_v); end
            exp_v = exp_q.pop_front(); checks++;
            if (rd_b_24 !== exp_v) begin errors++; $display("FAIL reset_mid_b24 addr=%0d got=%h exp=%h", waddrs[k], rd_b_24, exp_v); end
        end
        @(negedge clock) clr = 1'b1;
        for (int a = 0; a < 32; a++) begin
            raddr_a = a[4:0]; raddr_b = 5'(31 - a);
            exp_q.push_back(exp32(a)); exp_q.push_back(exp32(31 - a)); exp_q.push_back(exp24(a));
            #1;
            exp_v = exp_q.pop_front(); checks++;
            if (rdata_a !== exp_v) begin errors++; $display("FAIL reset_after_a addr=%0d got=%h exp=%h", a, rdata_a, exp_v); end
            exp_v = exp_q.pop_front(); checks++;
            if (rdata_b !== exp_v) begin errors++; $display("FAIL reset_after_b addr=%0d got=%h exp=%h", 31 - a, rdata_b, exp_v); end
            exp_v = exp_q.pop_front(); checks++;
            if (rd_a_24 !== exp_v) begin errors++; $display("FAIL reset_after_a24 addr=%0d got=%h exp=%h", a, rd_a_24, exp_v); end
        end
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 32; i++) do_write(i, 32'hA5A5_0000 + 32'(i));
        for (int a = 0; a < 32; a++) begin
            raddr_a = a[4:0]; raddr_b = a[4:0];
            exp_q.push_back(exp32(a)); exp_q.push_back(exp32(a));
            exp_q.push_back(exp24(a)); exp_q.push_back(exp24(a));
            #1;
            exp_v = exp_q.pop_front(); checks++;
            if (rdata_a !== exp_v) begin errors++; $display("FAIL sweep_a addr=%0d got=%h exp=%h", a, rdata_a, exp_v); end
            exp_v = exp_q.pop_front(); checks++;
            if (rdata_b !== exp_v) begin errors++; $display("FAIL sweep_b addr=%0d got=%h exp=%h", a, rdata_b, exp_v); end
            exp_v = exp_q.pop_front(); checks++;
            if (rd_a_24 !== exp_v) begin errors++; $display("FAIL sweep_a24 addr=%0d got=%h exp=%h", a, rd_a_24, exp_v); end
            exp_v = exp_q.pop_front(); checks++;
            if (rd_b_24 !== exp_v) begin errors++; $display("FAIL sweep_b24 addr=%0d got=%h exp=%h", a, rd_b_24, exp_v); end
        end
    endtask

    task automatic test_hazard();
        do_write(7, 32'hDEAD_BEEF);
`ifdef REGFILE_BYPASS_EN
        pre_v = 32'h1234_5678;
`else
        pre_v = 32'hDEAD_BEEF;
`endif
        @(negedge clock);
        we = 1'b1; waddr = 5'd7; wdata = 32'h1234_5678; raddr_a = 5'd7; raddr_b = 5'd6;
        exp_q.push_back(pre_v); exp_q.push_back(pre_v); exp_q.push_back(exp32(6));
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (rdata_a !== exp_v) begin errors++; $display("FAIL hazard_pre_a got=%h exp=%h", rdata_a, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (rd_a_24 !== exp_v) begin errors++; $display("FAIL hazard_pre_a24 got=%h exp=%h", rd_a_24, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (rdata_b !== exp_v) begin errors++; $display("FAIL hazard_pre_b_other got=%h exp=%h", rdata_b, exp_v); end
        @(posedge clock);
        model_write(7, 32'h1234_5678);
        #1;
        we = 1'b0;
        exp_q.push_back(exp32(7)); exp_q.push_back(exp24(7));
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (rdata_a !== exp_v) begin errors++; $display("FAIL hazard_post_a got=%h exp=%h", rdata_a, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (rd_a_24 !== exp_v) begin errors++; $display("FAIL hazard_post_a24 got=%h exp=%h", rd_a_24, exp_v); end
    endtask

    task automatic test_out_of_range();
        for (int a = 24; a < 32; a++) do_write(a, 32'hFFFF_FFFF);
        for (int a = 0; a < 32; a++) begin
            raddr_a = a[4:0]; raddr_b = a[4:0];
            exp_q.push_back(exp24(a)); exp_q.push_back(exp24(a)); exp_q.push_back(exp32(a));
            #1;
            exp_v = exp_q.pop_front(); checks++;
            if (rd_a_24 !== exp_v) begin errors++; $display("FAIL oor_a24 addr=%0d got=%h exp=%h", a, rd_a_24, exp_v); end
            exp_v = exp_q.pop_front(); checks++;
            if (rd_b_24 !== exp_v) begin errors++; $display("FAIL oor_b24 addr=%0d got=%h exp=%h", a, rd_b_24, exp_v); end
            exp_v = exp_q.pop_front(); checks++;
            if (rdata_a !== exp_v) begin errors++; $display("FAIL oor_a32 addr=%0d got=%h exp=%h", a, rdata_a, exp_v); end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            we = 1'b1; waddr = 5'd9; wdata = 32'h0000_0100 + 32'(k); raddr_a = 5'd9; raddr_b = 5'd9;
            @(posedge clock);
            model_write(9, 32'h0000_0100 + 32'(k));
            exp_q.push_back(exp32(9)); exp_q.push_back(exp24(9));
            #1;
            exp_v = exp_q.pop_front(); checks++;
            if (rdata_b !== exp_v) begin errors++; $display("FAIL b2b_b k=%0d got=%h exp=%h", k, rdata_b, exp_v); end
            exp_v = exp_q.pop_front(); checks++;
            if (rd_b_24 !== exp_v) begin errors++; $display("FAIL b2b_b24 k=%0d got=%h exp=%h", k, rd_b_24, exp_v); end
        end
        we = 1'b0;
    endtask

    task automatic test_reset_race();
        do_write(3, 32'h0000_0055);
        @(negedge clock);
        we = 1'b1; waddr = 5'd3; wdata = 32'h0000_0001;
        #3 clr = 1'b0;
        #4 clr = 1'b1;
        we = 1'b0;
        model_clear();
        raddr_a = 5'd3; raddr_b = 5'd3;
        exp_q.push_back(exp32(3)); exp_q.push_back(exp24(3));
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (rdata_a !== exp_v) begin errors++; $display("FAIL race_a got=%h exp=%h", rdata_a, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (rd_b_24 !== exp_v) begin errors++; $display("FAIL race_b24 got=%h exp=%h", rd_b_24, exp_v); end
    endtask

    task automatic test_width();
        logic [7:0] got;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            we8 = 1'b1;
            waddr8 = (k == 0) ? 2'd2 : ((k == 1) ? 2'd0 : 2'd1);
            wdata8 = (k == 0) ? 8'hFF : ((k == 1) ? 8'h5A : 8'h3C);
            @(posedge clock);
            if (waddr8 != 2'd0) mdl8[waddr8] = wdata8;
            #1 we8 = 1'b0;
        end
        for (int a = 0; a < 4; a++) begin
            rb8 = a[1:0]; ra8 = 2'(3 - a);
            exp_q.push_back({24'd0, mdl8[a]}); exp_q.push_back({24'd0, mdl8[3 - a]});
            #1;
            exp_v = exp_q.pop_front(); got = rd_b8; checks++;
            if (got !== exp_v[7:0]) begin errors++; $display("FAIL width_b addr=%0d got=%h exp=%h", a, got, exp_v[7:0]); end
            exp_v = exp_q.pop_front(); got = rd_a8; checks++;
            if (got !== exp_v[7:0]) begin errors++; $display("FAIL width_a addr=%0d got=%h exp=%h", 3 - a, got, exp_v[7:0]); end
        end
    endtask

    initial begin
        clr = 1'b1; we = 1'b0; waddr = 5'd0; wdata = 32'd0; raddr_a = 5'd0; raddr_b = 5'd0;
        we8 = 1'b0; waddr8 = 2'd0; wdata8 = 8'd0; ra8 = 2'd0; rb8 = 2'd0;
        model_clear();
        test_reset();
        test_sweep();
        test_hazard();
        test_out_of_range();
        test_back_to_back();
        test_reset_race();
        test_width();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
